// File: rtl/op_group_pkg.sv
// op_group_pkg: shared types for the operand group fetch slice.
//   GROUP_SIZE       - operands per bundle (fixed at 4, tied to the queue's
//                      "fewer than 4 past checkpoint" empty flag)
//   op_group_state_t - fetch FSM state encoding
//   op_group_t       - bundle of GROUP_SIZE operands of `OP_SIZE bits,
//                      element 0 is the operand popped first
`ifndef OP_SIZE
`define OP_SIZE 8
`endif

package op_group_pkg;

  localparam int GROUP_SIZE = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_VALID    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_COMMIT   = 3'd4,
    ST_RETRY    = 3'd5
  } op_group_state_t;

  typedef logic [GROUP_SIZE-1:0][`OP_SIZE-1:0] op_group_t;

endpackage

// File: rtl/op_group_fetch_if.sv
// op_group_fetch_if: queue-side and execute-side signals of the group fetcher.
//   queue side  : q_data, q_empty (from queue); q_pop, q_reset, q_next (to queue)
//   execute side: grp_valid, grp_data (to execute); grp_ready, grp_commit,
//                 grp_retry (from execute)
//   modport master - the fetcher
//   modport slave  - the queue/execute environment
`ifndef OP_SIZE
`define OP_SIZE 8
`endif

interface op_group_fetch_if #(
  parameter int OP_W       = `OP_SIZE,
  parameter int GROUP_SIZE = op_group_pkg::GROUP_SIZE
);

  logic [OP_W-1:0]            q_data;
  logic                       q_empty;
  logic                       q_pop;
  logic                       q_reset;
  logic                       q_next;
  logic                       grp_valid;
  logic                       grp_ready;
  logic [GROUP_SIZE*OP_W-1:0] grp_data;
  logic                       grp_commit;
  logic                       grp_retry;

  modport master (
    input  q_data, q_empty, grp_ready, grp_commit, grp_retry,
    output q_pop, q_reset, q_next, grp_valid, grp_data
  );

  modport slave (
    output q_data, q_empty, grp_ready, grp_commit, grp_retry,
    input  q_pop, q_reset, q_next, grp_valid, grp_data
  );

endinterface

// File: rtl/op_group_stats.sv
// op_group_stats: saturating 16-bit commit/retry event counters.
//   clk, rst    - clock, async active-high reset (clears both counters)
//   commit_stb  - one-cycle strobe on entry to COMMIT
//   retry_stb   - one-cycle strobe on entry to RETRY
//   cnt_commit  - number of commits, sticks at 0xFFFF
//   cnt_retry   - number of retries, sticks at 0xFFFF
module op_group_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_stb,
  input  logic        retry_stb,
  output logic [15:0] cnt_commit,
  output logic [15:0] cnt_retry
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_commit <= '0;
      cnt_retry  <= '0;
    end else begin
      if (commit_stb && (cnt_commit != 16'hFFFF)) cnt_commit <= cnt_commit + 16'd1;
      if (retry_stb && (cnt_retry != 16'hFFFF))   cnt_retry  <= cnt_retry + 16'd1;
    end
  end

endmodule

// File: rtl/op_group_fetch.sv
// op_group_fetch: pops four operands from the operand queue into a bundle,
// offers it to execute, then advances (commit) or rewinds (retry) the queue.
//   clk, rst   - clock, async active-high reset (shared with the queue)
//   bus        - op_group_fetch_if.master (queue + execute handshake)
//   busy       - FSM not in IDLE
//   cnt_commit, cnt_retry - saturating event counters, only when the
//                macro OP_GROUP_CNT_EN is defined
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | wait for at least 4 operands past the queue checkpoint
// LOAD     | pop one operand per cycle into slot idx (4 cycles)
// VALID    | bundle offered, grp_valid=1 until grp_ready
// WAIT_RES | bundle accepted, wait for commit/retry verdict
// COMMIT   | one-cycle q_next, queue checkpoint moves to read pointer
// RETRY    | one-cycle q_reset, queue read pointer rewinds to checkpoint
`ifndef OP_SIZE
`define OP_SIZE 8
`endif

module op_group_fetch #(
  parameter int OP_W       = `OP_SIZE,
  parameter int GROUP_SIZE = op_group_pkg::GROUP_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  op_group_fetch_if.master      bus,
  output logic                  busy
`ifdef OP_GROUP_CNT_EN
  ,
  output logic [15:0]           cnt_commit,
  output logic [15:0]           cnt_retry
`endif
);

  import op_group_pkg::*;

  // The queue's empty flag is hard-wired to a threshold of 4.
  if (GROUP_SIZE != 4) begin : g_bad_group_size
    $error("op_group_fetch: GROUP_SIZE must be 4");
  end

  localparam int IDX_W = $clog2(GROUP_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GROUP_SIZE - 1);

  op_group_state_t                  state, state_nxt;
  logic [IDX_W-1:0]                 idx;
  logic [GROUP_SIZE-1:0][OP_W-1:0]  slots;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      slots <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        idx <= '0;
      end else if (state == ST_LOAD) begin
        slots[idx] <= bus.q_data;
        idx        <= idx + 1'b1;
      end
    end
  end

  // Queue strobes and grp_valid depend on state only, so they cannot
  // glitch on queue or execute inputs.
  always_comb begin
    state_nxt     = state;
    bus.q_pop     = 1'b0;
    bus.q_reset   = 1'b0;
    bus.q_next    = 1'b0;
    bus.grp_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!bus.q_empty) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.q_pop = 1'b1;
        if (idx == IDX_LAST) state_nxt = ST_VALID;
      end
      ST_VALID: begin
        bus.grp_valid = 1'b1;
        if (bus.grp_ready) state_nxt = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (bus.grp_retry)       state_nxt = ST_RETRY;
        else if (bus.grp_commit) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        bus.q_next = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_RETRY: begin
        bus.q_reset = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.grp_data = slots;

`ifdef OP_GROUP_CNT_EN
  logic commit_stb, retry_stb;

  assign retry_stb  = (state == ST_WAIT_RES) && bus.grp_retry;
  assign commit_stb = (state == ST_WAIT_RES) && bus.grp_commit && !bus.grp_retry;

  op_group_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .commit_stb (commit_stb),
    .retry_stb  (retry_stb),
    .cnt_commit (cnt_commit),
    .cnt_retry  (cnt_retry)
  );
`endif

endmodule

// File: tb/tb_op_group_fetch.sv
// tb_op_group_fetch: directed bench for op_group_fetch with OP_W=8 and a
// behavioural operand queue (write pointer, read pointer, checkpoint).
// Counter checks are active when OP_GROUP_CNT_EN is defined.
module tb_op_group_fetch;

  localparam int OP_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef OP_GROUP_CNT_EN
  logic [15:0] cnt_commit, cnt_retry;
`endif

  always #5 clk = ~clk;

  op_group_fetch_if #(.OP_W(OP_W), .GROUP_SIZE(4)) bus ();

  op_group_fetch #(.OP_W(OP_W), .GROUP_SIZE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy)
`ifdef OP_GROUP_CNT_EN
    ,
    .cnt_commit (cnt_commit),
    .cnt_retry  (cnt_retry)
`endif
  );

  // queue model
  logic [7:0] qmem [0:63];
  logic [5:0] wr_ptr, rd_ptr, ck_ptr;
  logic       push_en = 1'b0;
  logic [7:0] push_data = '0;
  logic [5:0] fill;

  assign fill         = wr_ptr - ck_ptr;
  assign bus.q_data   = qmem[rd_ptr];
  assign bus.q_empty  = (fill < 6'd4);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ck_ptr <= '0;
    end else begin
      if (push_en) begin
        qmem[wr_ptr] <= push_data;
        wr_ptr       <= wr_ptr + 6'd1;
      end
      if (bus.q_reset)    rd_ptr <= ck_ptr;
      else if (bus.q_pop) rd_ptr <= rd_ptr + 6'd1;
      if (bus.q_next) ck_ptr <= rd_ptr;
    end
  end

  int pop_cnt = 0, next_cnt = 0, reset_cnt = 0;
  always @(posedge clk) begin
    if (bus.q_pop)   pop_cnt   <= pop_cnt + 1;
    if (bus.q_next)  next_cnt  <= next_cnt + 1;
    if (bus.q_reset) reset_cnt <= reset_cnt + 1;
  end

  // {q_pop, q_reset, q_next, grp_valid, busy}
  logic [4:0] ctrl;
  assign ctrl = {bus.q_pop, bus.q_reset, bus.q_next, bus.grp_valid, busy};

  int vec = 0;
  int errs = 0;

  task automatic push4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      push_en   = 1'b1;
      push_data = w[i*8 +: 8];
      @(negedge clk);
    end
    push_en = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.grp_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vec++; if (ctrl !== 5'b00000) begin errs++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 5'b00000); end
    vec++; if (bus.grp_data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h want %h", bus.grp_data, 32'h0); end
`ifdef OP_GROUP_CNT_EN
    vec++; if ({cnt_commit, cnt_retry} !== 32'h0) begin errs++; $display("FAIL reset_cnt: got %h want %h", {cnt_commit, cnt_retry}, 32'h0); end
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (ctrl !== 5'b00000) begin errs++; $display("FAIL idle_empty: got %b want %b", ctrl, 5'b00000); end
  endtask

  task automatic test_fetch_commit();
    int p0;
    bus.grp_ready = 1'b1;
    p0 = pop_cnt;
    push4(32'h44332211);
    // cycle 0: q_empty just went low, DUT still IDLE
    vec++; if ({bus.q_empty, busy} !== 2'b00) begin errs++; $display("FAIL fetch_c0: got %b want %b", {bus.q_empty, busy}, 2'b00); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vec++; if (ctrl !== 5'b10001) begin errs++; $display("FAIL fetch_pop_c%0d: got %b want %b", c, ctrl, 5'b10001); end
    end
    @(negedge clk);
    vec++; if (ctrl !== 5'b00011) begin errs++; $display("FAIL fetch_valid_c5: got %b want %b", ctrl, 5'b00011); end
    vec++; if (bus.grp_data !== 32'h44332211) begin errs++; $display("FAIL fetch_data: got %h want %h", bus.grp_data, 32'h44332211); end
    vec++; if (pop_cnt - p0 !== 4) begin errs++; $display("FAIL fetch_pops: got %0d want %0d", pop_cnt - p0, 4); end
    @(negedge clk);
    vec++; if (ctrl !== 5'b00001) begin errs++; $display("FAIL wait_res: got %b want %b", ctrl, 5'b00001); end
    bus.grp_commit = 1'b1;
    @(negedge clk);
    bus.grp_commit = 1'b0;
    vec++; if (ctrl !== 5'b00101) begin errs++; $display("FAIL commit_pulse: got %b want %b", ctrl, 5'b00101); end
    @(negedge clk);
    vec++; if (ctrl !== 5'b00000) begin errs++; $display("FAIL commit_idle: got %b want %b", ctrl, 5'b00000); end
    p0 = pop_cnt;
    repeat (5) @(negedge clk);
    vec++; if ({pop_cnt - p0, 31'(busy)} !== {32'd0, 31'd0}) begin errs++; $display("FAIL after_commit: got pops %0d busy %b want pops 0 busy 0", pop_cnt - p0, busy); end
`ifdef OP_GROUP_CNT_EN
    vec++; if ({cnt_commit, cnt_retry} !== {16'd1, 16'd0}) begin errs++; $display("FAIL cnt_after_commit: got %h want %h", {cnt_commit, cnt_retry}, {16'd1, 16'd0}); end
`endif
  endtask

  task automatic test_retry();
    bit ok;
    int p0;
    push4(32'h44332211);
    wait_valid(10, ok);
    vec++; if (!ok) begin errs++; $display("FAIL retry_first_valid: got no grp_valid want grp_valid within 10 cycles"); end
    @(negedge clk);
    bus.grp_retry = 1'b1;
    @(negedge clk);
    bus.grp_retry = 1'b0;
    vec++; if (ctrl !== 5'b01001) begin errs++; $display("FAIL retry_pulse: got %b want %b", ctrl, 5'b01001); end
    vec++; if (bus.grp_data !== 32'h44332211) begin errs++; $display("FAIL retry_hold: got %h want %h", bus.grp_data, 32'h44332211); end
    @(negedge clk);
    vec++; if (ctrl !== 5'b00000) begin errs++; $display("FAIL retry_idle: got %b want %b", ctrl, 5'b00000); end
    p0 = pop_cnt;
    wait_valid(10, ok);
    vec++; if (!ok) begin errs++; $display("FAIL refetch_valid: got no grp_valid want grp_valid within 10 cycles"); end
    vec++; if (pop_cnt - p0 !== 4) begin errs++; $display("FAIL refetch_pops: got %0d want %0d", pop_cnt - p0, 4); end
    vec++; if (bus.grp_data !== 32'h44332211) begin errs++; $display("FAIL refetch_data: got %h want %h", bus.grp_data, 32'h44332211); end
`ifdef OP_GROUP_CNT_EN
    vec++; if ({cnt_commit, cnt_retry} !== {16'd1, 16'd1}) begin errs++; $display("FAIL cnt_after_retry: got %h want %h", {cnt_commit, cnt_retry}, {16'd1, 16'd1}); end
`endif
    @(negedge clk);
    bus.grp_commit = 1'b1;
    @(negedge clk);
    bus.grp_commit = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    int n0, r0;
    bus.grp_ready = 1'b0;
    push4(32'h04030201);
    wait_valid(10, ok);
    vec++; if (!ok) begin errs++; $display("FAIL stall_valid: got no grp_valid want grp_valid within 10 cycles"); end
    n0 = next_cnt;
    r0 = reset_cnt;
    for (int i = 0; i < 10; i++) begin
      // verdicts outside WAIT_RES must be ignored
      if (i == 3) begin bus.grp_commit = 1'b1; bus.grp_retry = 1'b1; end
      if (i == 6) begin bus.grp_commit = 1'b0; bus.grp_retry = 1'b0; end
      @(negedge clk);
      vec++; if ({bus.grp_valid, bus.grp_data} !== {1'b1, 32'h04030201}) begin errs++; $display("FAIL stall_hold_%0d: got %b/%h want 1/%h", i, bus.grp_valid, bus.grp_data, 32'h04030201); end
    end
    vec++; if ({next_cnt - n0, reset_cnt - r0} !== {32'd0, 32'd0}) begin errs++; $display("FAIL stall_ignore: got next %0d reset %0d want 0 0", next_cnt - n0, reset_cnt - r0); end
    bus.grp_ready = 1'b1;
    @(negedge clk);
    vec++; if (ctrl !== 5'b00001) begin errs++; $display("FAIL stall_accept: got %b want %b", ctrl, 5'b00001); end
    bus.grp_commit = 1'b1;
    @(negedge clk);
    bus.grp_commit = 1'b0;
    vec++; if (ctrl !== 5'b00101) begin errs++; $display("FAIL stall_commit: got %b want %b", ctrl, 5'b00101); end
    @(negedge clk);
  endtask

  task automatic test_both_verdicts();
    bit ok;
    int n0;
    n0 = next_cnt;
    push4(32'hefbeadde);
    wait_valid(10, ok);
    vec++; if (!ok) begin errs++; $display("FAIL both_valid: got no grp_valid want grp_valid within 10 cycles"); end
    @(negedge clk);
    bus.grp_commit = 1'b1;
    bus.grp_retry  = 1'b1;
    @(negedge clk);
    bus.grp_commit = 1'b0;
    bus.grp_retry  = 1'b0;
    vec++; if (ctrl !== 5'b01001) begin errs++; $display("FAIL both_retry_wins: got %b want %b", ctrl, 5'b01001); end
    wait_valid(12, ok);
    vec++; if (!ok) begin errs++; $display("FAIL both_refetch: got no grp_valid want grp_valid within 12 cycles"); end
    vec++; if (bus.grp_data !== 32'hefbeadde) begin errs++; $display("FAIL both_data: got %h want %h", bus.grp_data, 32'hefbeadde); end
    vec++; if (next_cnt - n0 !== 0) begin errs++; $display("FAIL both_no_next: got %0d want %0d", next_cnt - n0, 0); end
`ifdef OP_GROUP_CNT_EN
    vec++; if ({cnt_commit, cnt_retry} !== {16'd3, 16'd2}) begin errs++; $display("FAIL cnt_after_both: got %h want %h", {cnt_commit, cnt_retry}, {16'd3, 16'd2}); end
`endif
    @(negedge clk);
    bus.grp_commit = 1'b1;
    @(negedge clk);
    bus.grp_commit = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_midload();
    bit ok;
    int p0;
    push4(32'h88776655);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vec++; if (pop_cnt - 0 < 2 || ctrl !== 5'b10001) begin errs++; $display("FAIL midload_state: got %b want %b", ctrl, 5'b10001); end
    rst = 1'b1;
    #1;
    vec++; if (ctrl !== 5'b00000) begin errs++; $display("FAIL midload_rst_ctrl: got %b want %b", ctrl, 5'b00000); end
    vec++; if (bus.grp_data !== 32'h0) begin errs++; $display("FAIL midload_rst_data: got %h want %h", bus.grp_data, 32'h0); end
`ifdef OP_GROUP_CNT_EN
    vec++; if ({cnt_commit, cnt_retry} !== 32'h0) begin errs++; $display("FAIL midload_rst_cnt: got %h want %h", {cnt_commit, cnt_retry}, 32'h0); end
`endif
    @(negedge clk);
    rst = 1'b0;
    p0 = pop_cnt;
    repeat (10) @(negedge clk);
    vec++; if ({pop_cnt - p0, 31'(busy)} !== {32'd0, 31'd0}) begin errs++; $display("FAIL post_rst_idle: got pops %0d busy %b want pops 0 busy 0", pop_cnt - p0, busy); end
    p0 = pop_cnt;
    push4(32'hf0debc9a);
    wait_valid(10, ok);
    vec++; if (!ok) begin errs++; $display("FAIL post_rst_valid: got no grp_valid want grp_valid within 10 cycles"); end
    vec++; if ({pop_cnt - p0, bus.grp_data} !== {32'd4, 32'hf0debc9a}) begin errs++; $display("FAIL post_rst_fetch: got pops %0d data %h want pops 4 data %h", pop_cnt - p0, bus.grp_data, 32'hf0debc9a); end
    @(negedge clk);
    bus.grp_commit = 1'b1;
    @(negedge clk);
    bus.grp_commit = 1'b0;
    @(negedge clk);
`ifdef OP_GROUP_CNT_EN
    vec++; if ({cnt_commit, cnt_retry} !== {16'd1, 16'd0}) begin errs++; $display("FAIL post_rst_cnt: got %h want %h", {cnt_commit, cnt_retry}, {16'd1, 16'd0}); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.grp_ready  = 1'b0;
    bus.grp_commit = 1'b0;
    bus.grp_retry  = 1'b0;
    test_reset();
    test_fetch_commit();
    test_retry();
    test_stall();
    test_both_verdicts();
    test_rst_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/op_group_fetch.md
# op_group_fetch

Downstream consumer of the operand storage queue. Pops operands one per cycle into a fixed bundle of four and presents the bundle to the execute stage over a valid/ready handshake. Waits for a commit/retry verdict. On commit it pulses the queue's `next` (advance checkpoint). On retry it pulses the queue's `reset` (rewind read pointer to checkpoint) and re-fetches the same bundle.

## Interface

Parameters:
- `OP_W`, default `` `OP_SIZE ``: width of one operand.
- `GROUP_SIZE`, default 4: operands per bundle. Fixed at 4, because the queue's `empty` flag means "fewer than 4 entries past checkpoint". Any other value is illegal and must be caught by an elaboration-time check.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `q_data`, in, OP_W: queue head operand, combinational from the queue.
- `q_empty`, in, 1: queue has fewer than 4 operands past checkpoint.
- `q_pop`, out, 1: advance queue read pointer.
- `q_reset`, out, 1: rewind queue read pointer to checkpoint.
- `q_next`, out, 1: set queue checkpoint to the current read pointer.
- `grp_valid`, out, 1: bundle available.
- `grp_ready`, in, 1: execute stage accepts the bundle.
- `grp_data`, out, GROUP_SIZE*OP_W: bundle. Operand popped first is in bits [OP_W-1:0].
- `grp_commit`, in, 1: bundle retired.
- `grp_retry`, in, 1: bundle must be replayed.
- `busy`, out, 1: state is not IDLE.
- `cnt_commit`, `cnt_retry`, out, 16 each: present only with `OP_GROUP_CNT_EN`.

## Operation

- FSM states: IDLE, LOAD, VALID, WAIT_RES, COMMIT, RETRY. State register resets to IDLE.
- IDLE: if `q_empty`=0, go to LOAD and clear slot index `idx`.
- LOAD: `q_pop`=1. At each edge, capture `q_data` into slot `idx` and increment `idx`. After slot 3, go to VALID.
- VALID: `grp_valid`=1. On `grp_valid & grp_ready`, go to WAIT_RES.
- WAIT_RES: wait for a verdict.
  - `grp_retry`=1: go to RETRY. Retry wins over a simultaneous commit.
  - `grp_commit`=1 only: go to COMMIT.
- COMMIT: `q_next`=1 for exactly one cycle, then IDLE.
- RETRY: `q_reset`=1 for exactly one cycle, then IDLE. The re-fetch reloads identical operands.
- `q_pop`, `q_next` and `q_reset` are decoded from the state register only. They are mutually exclusive and never glitch on inputs.
- `grp_commit`/`grp_retry` outside WAIT_RES are ignored.
- `grp_data` is held stable from entry to VALID until the next LOAD overwrites it.
- `rst` at any time, including mid-LOAD, returns to IDLE with all outputs 0. The queue shares `rst`, so no partial bundle survives.

## Timing

- Reset values: `q_pop`, `q_reset`, `q_next`, `grp_valid`, `busy` = 0; `grp_data` = 0; counters = 0.
- Latency:
  - `q_empty` low in cycle 0 → `q_pop` high in cycles 1-4 → `grp_valid` high in cycle 5.
  - Handshake edge at end of cycle H → WAIT_RES in H+1.
  - Verdict sampled in cycle T → `q_next`/`q_reset` high in T+1 → IDLE in T+2. `q_empty` is re-sampled in T+2, after the queue checkpoint/pointer has updated.
- Throughput: one bundle per 8 cycles minimum, assuming ready and verdict arrive immediately.
- `grp_valid` is never dropped without a handshake.

## Configuration

- `OP_GROUP_CNT_EN` defined:
  - `cnt_commit` increments on each COMMIT entry.
  - `cnt_retry` increments on each RETRY entry.
  - Both are 16-bit and saturate at 0xFFFF. Both are cleared only by `rst`.
- `OP_GROUP_CNT_EN` undefined: the counter ports and logic are absent.

## Structure

- Shared package `op_group_pkg` holds:
  - `GROUP_SIZE` constant;
  - FSM state enum `op_group_state_t`;
  - bundle typedef `op_group_t`, an array of GROUP_SIZE operands of `` `OP_SIZE `` bits.
- Sub-module `op_group_stats` holds the two saturating counters. It is instantiated only under `OP_GROUP_CNT_EN` and is driven by one-cycle COMMIT/RETRY entry strobes.

## Test plan

- Push 0x11,0x22,0x33,0x44 (OP_W=8), ready=1: exactly 4 `q_pop` cycles, then `grp_data`=0x44332211 with `grp_valid` in cycle 5.
- Commit the bundle: `q_next` pulses one cycle. Queue empty afterwards, so no further `q_pop`; `busy`=0.
- Retry the bundle: `q_reset` pulses one cycle, then 4 pops reissue 0x44332211. With the macro enabled, `cnt_retry`=1.
- `grp_ready` held low 10 cycles in VALID: `grp_valid` stays 1 and `grp_data` stays constant.
- `grp_commit` and `grp_retry` high in the same cycle: retry path taken, `q_next` never asserts, and `cnt_commit` is unchanged.
- `rst` asserted after 2 pops in LOAD: all outputs 0 immediately. After release, no `q_pop` until 4 new operands are pushed.
